vco_table_ctrl: RTL
===================

# vco_table_ctrl

Sequencing controller placed in front of `vco`. It loads the cos/sin lookup tables through the VCO's always-enabled write ports from a valid/ready sample stream. It holds off the modulation (`voltage_signal`) stream until a complete table is resident, and schedules table reloads so they start only on packet boundaries.

## Interface
- `VCO_BIT_WIDTH`, 16, width of voltage samples
- `SIN_COS_ADDR_BIT_WIDTH`, 11, table address width; table depth D = 2^SIN_COS_ADDR_BIT_WIDTH
- `IQ_BIT_WIDTH`, 8, signed table entry width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset: asynchronous, active-high
- `load_start`  in  1  request a (re)load of both tables; single-cycle pulse
- `tbl_cos`  in  IQ_BIT_WIDTH  signed cos entry for the current address
- `tbl_sin`  in  IQ_BIT_WIDTH  signed sin entry for the current address
- `tbl_valid`  in  1  table beat valid
- `tbl_ready`  out  1  table beat accepted when `tbl_valid & tbl_ready`
- `cos_table_write_address`, `sin_table_write_address`  out  SIN_COS_ADDR_BIT_WIDTH  to vco; always equal
- `cos_table_write_data`, `sin_table_write_data`  out  IQ_BIT_WIDTH  to vco
- `in_voltage`  in  VCO_BIT_WIDTH  upstream voltage sample
- `in_valid`  in  1  upstream sample valid
- `in_valid_last`  in  1  last sample of a packet; qualified by `in_valid`
- `in_ready`  out  1  upstream beat accepted when `in_valid & in_ready`
- `voltage_signal`  out  VCO_BIT_WIDTH  to vco
- `voltage_signal_valid`  out  1  to vco
- `voltage_signal_valid_last`  out  1  to vco
- `table_loaded`  out  1  a complete table is resident
- `load_done`  out  1  one-cycle pulse when the final entry is written

## Operation
- States: EMPTY (no table), LOAD, RUN, DRAIN.
- Reset values:
  - state = EMPTY.
  - All outputs 0, including both write addresses and both write data.
  - `in_ready`, `tbl_ready`, `table_loaded` and `load_done` are all 0.
- EMPTY:
  - `in_ready`=0, `tbl_ready`=0.
  - `load_start` moves the FSM to LOAD and clears the address counter.
- LOAD:
  - `tbl_ready`=1 and `in_ready`=0; `table_loaded`=0.
  - Each accepted beat registers address = counter, cos data = `tbl_cos`, sin data = `tbl_sin`, then counter+1.
  - Acceptance of address D-1 moves the FSM to RUN, sets `table_loaded`, and pulses `load_done`.
  - `load_start` during LOAD is ignored; loading does not restart.
- Write-port hold rule (the vco write enable is permanently high):
  - In every cycle without an accepted beat, the write address and data keep their previous values, so the RAM rewrites an identical value.
  - The write address and data must never change without the matching data.
- RUN:
  - `in_ready`=1 and `tbl_ready`=0.
  - An accepted beat registers `voltage_signal`=`in_voltage`, with valid=1 and last=`in_valid_last`.
  - A cycle with no accepted beat drives valid=0 and last=0; `voltage_signal` holds its value.
  - `pkt_active` is set by an accepted non-last beat and cleared by an accepted last beat.
- `load_start` in RUN:
  - `pkt_active`=0 and no beat accepted this cycle: go to LOAD.
  - Otherwise go to DRAIN.
  - If the same-cycle beat is a last beat: go to LOAD.
- DRAIN:
  - `in_ready`=1 and beats are forwarded as in RUN; `table_loaded` stays 1.
  - Acceptance of the last beat moves the FSM to LOAD on the next cycle.
  - Further `load_start` pulses are ignored.
- Entering LOAD from RUN or DRAIN clears `table_loaded` and the counter.
- `in_valid_last` without `in_valid` is ignored.
- Reset mid-load: EMPTY, with the partial table discarded logically; a new `load_start` is required.

## Timing
- Table path latency: beat accepted at cycle T → write port outputs valid at T+1; the RAM is written at the end of T+1.
- Final beat at T:
  - State is RUN, `load_done`=1 and `in_ready`=1 at T+1.
  - A voltage beat accepted at T+1 appears at vco input at T+2.
  - Its phase lookup therefore follows the final write.
- Voltage path: fixed 1-cycle latency; full throughput, 1 beat/cycle in RUN and DRAIN.
- Table path: full throughput, D beats in D cycles minimum.
- `in_ready` and `tbl_ready` are registered, decoded from state only; they never depend combinationally on `*_valid`.

## Structure
- Package `vco_table_ctrl_pkg` holds:
  - the state encoding localparams (EMPTY, LOAD, RUN, DRAIN);
  - the default width constants shared with `vco`.
- Flat module with no sub-module. The parent instantiates `vco` beside this block and wires the write and voltage ports directly.

## Test plan
Use D=2048 throughout.
- **Reset idle:** reset, then drive `in_valid`=1 for 10 cycles → `in_ready`=0 and `voltage_signal_valid`=0 throughout; all outputs 0.
- **Full load:** `load_start`, then 2048 beats with cos=addr[7:0], sin=~addr[7:0], with random `tbl_valid` gaps.
  - Each address is written exactly with its data.
  - The write outputs hold during gaps.
  - `load_done` pulses once, one cycle after beat 2047.
  - `table_loaded`=1 afterwards.
- **Forward:** in RUN, send a 5-beat packet of 100, 200, −300, 400, 5 → identical values one cycle later; `voltage_signal_valid_last` is high only on 5.
- **Reload mid-packet:** `load_start` on beat 2 of an 8-beat packet.
  - Remaining beats 3–8 are forwarded.
  - `tbl_ready` rises the cycle after beat 8.
  - `table_loaded` is 0 from then on.
- **Simultaneous events:** `load_start` in the same cycle as an accepted last beat → LOAD next cycle, with no further beats accepted. A second `load_start` during LOAD → no counter restart.
- **Async reset mid-load:** assert at address 1000 → immediate EMPTY with outputs 0; a reload then writes from address 0.

Source files
------------

// File: rtl/vco_table_ctrl_pkg.sv
// rtl/vco_table_ctrl_pkg.sv - state encoding and default widths shared by vco_table_ctrl and vco
package vco_table_ctrl_pkg;

  localparam int VCO_BIT_WIDTH_DEF          = 16;
  localparam int SIN_COS_ADDR_BIT_WIDTH_DEF = 11;
  localparam int IQ_BIT_WIDTH_DEF           = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // States in which the voltage stream flows and a complete table is resident
  function automatic logic is_stream_state(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/vco_table_ctrl.sv
// rtl/vco_table_ctrl.sv - loads the vco cos/sin tables from a stream and gates the voltage stream
// until a full table is resident; reloads start only on packet boundaries.
module vco_table_ctrl
  import vco_table_ctrl_pkg::*;
#(
  parameter int VCO_BIT_WIDTH          = VCO_BIT_WIDTH_DEF,
  parameter int SIN_COS_ADDR_BIT_WIDTH = SIN_COS_ADDR_BIT_WIDTH_DEF,
  parameter int IQ_BIT_WIDTH           = IQ_BIT_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic signed [IQ_BIT_WIDTH-1:0]    tbl_cos,
  input  logic signed [IQ_BIT_WIDTH-1:0]    tbl_sin,
  input  logic                              tbl_valid,
  output logic                              tbl_ready,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0] cos_table_write_address,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0] sin_table_write_address,
  output logic signed [IQ_BIT_WIDTH-1:0]    cos_table_write_data,
  output logic signed [IQ_BIT_WIDTH-1:0]    sin_table_write_data,
  input  logic [VCO_BIT_WIDTH-1:0]          in_voltage,
  input  logic                              in_valid,
  input  logic                              in_valid_last,
  output logic                              in_ready,
  output logic [VCO_BIT_WIDTH-1:0]          voltage_signal,
  output logic                              voltage_signal_valid,
  output logic                              voltage_signal_valid_last,
  output logic                              table_loaded,
  output logic                              load_done
);

  localparam logic [SIN_COS_ADDR_BIT_WIDTH-1:0] LAST_ADDR = '1;

  state_t                              state;
  state_t                              state_nxt;
  logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   cnt;
  logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   wr_addr;
  logic                                pkt_active;

  logic tbl_acc;
  logic in_acc;
  logic final_beat;
  logic enter_load;
  logic tbl_ready_nxt;
  logic in_ready_nxt;
  logic table_loaded_nxt;
  logic load_done_nxt;

  assign tbl_acc    = tbl_valid & tbl_ready;
  assign in_acc     = in_valid & in_ready;
  assign final_beat = tbl_acc & (cnt == LAST_ADDR);
  assign enter_load = (state_nxt == ST_LOAD) && (state != ST_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (load_start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (final_beat) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A reload may only begin between packets; otherwise finish the open packet first
        if (load_start) begin
          if (in_acc && in_valid_last)       state_nxt = ST_LOAD;
          else if (!pkt_active && !in_acc)   state_nxt = ST_LOAD;
          else                               state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (in_acc && in_valid_last) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Ready flags are registered copies of the next-state decode, so they track state exactly
  always_comb begin
    tbl_ready_nxt    = (state_nxt == ST_LOAD);
    in_ready_nxt     = is_stream_state(state_nxt);
    table_loaded_nxt = is_stream_state(state_nxt);
    load_done_nxt    = (state == ST_LOAD) && final_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_ready    <= 1'b0;
      in_ready     <= 1'b0;
      table_loaded <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      tbl_ready    <= tbl_ready_nxt;
      in_ready     <= in_ready_nxt;
      table_loaded <= table_loaded_nxt;
      load_done    <= load_done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (enter_load) begin
      cnt <= '0;
    end else if (tbl_acc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // vco write enable is tied high: address and data only ever move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr              <= '0;
      cos_table_write_data <= '0;
      sin_table_write_data <= '0;
    end else if (tbl_acc) begin
      wr_addr              <= cnt;
      cos_table_write_data <= tbl_cos;
      sin_table_write_data <= tbl_sin;
    end
  end

  assign cos_table_write_address = wr_addr;
  assign sin_table_write_address = wr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voltage_signal            <= '0;
      voltage_signal_valid      <= 1'b0;
      voltage_signal_valid_last <= 1'b0;
      pkt_active                <= 1'b0;
    end else begin
      if (in_acc) begin
        voltage_signal <= in_voltage;
        pkt_active     <= ~in_valid_last;
      end
      voltage_signal_valid      <= in_acc;
      voltage_signal_valid_last <= in_acc & in_valid_last;
    end
  end

endmodule
